// File: rtl/axis_red_pitaya_adc_capture_if.sv
// AXI4-Stream bus bundle (tdata/tvalid/tready) shared by the capture core and its consumer.
//   master: drives tdata/tvalid, samples tready
//   slave : samples tdata/tvalid, drives tready
interface axis_if #(
  parameter int unsigned TDATA_WIDTH = 32
) ();
  logic [TDATA_WIDTH-1:0] tdata;
  logic                   tvalid;
  logic                   tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_red_pitaya_adc_capture.sv
// Red Pitaya ADC receive path: registers both ADC channels, converts offset-binary
// to two's complement, box-car averages over 2^N samples and presents each result
// on a single-entry AXI4-Stream output register. Results arriving while the output
// is stalled are dropped and counted; sampling never stalls.
// Ports:
//   aclk, areset         ADC sample clock, synchronous active-high reset
//   adc_dat_a/b          raw offset-binary samples, channel A/B
//   adc_csn              ADC chip select, tied high
//   cfg_dec_log2         averaging exponent N, latched at each block start
//   m_axis               stream master: [HALF-1:0] channel A, [2*HALF-1:HALF] channel B
//   sts_overflow         sticky flag, at least one result dropped
//   sts_drop_cnt         saturating count of dropped results
module axis_red_pitaya_adc_capture #(
  parameter int unsigned ADC_DATA_WIDTH   = 14,
  parameter int unsigned AXIS_TDATA_WIDTH = 32,
  parameter int unsigned DEC_LOG2_WIDTH   = 3,
  parameter int unsigned DROP_CNT_WIDTH   = 16
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [ADC_DATA_WIDTH-1:0] adc_dat_a,
  input  logic [ADC_DATA_WIDTH-1:0] adc_dat_b,
  output logic                      adc_csn,
  input  logic [DEC_LOG2_WIDTH-1:0] cfg_dec_log2,
  axis_if.master                    m_axis,
  output logic                      sts_overflow,
  output logic [DROP_CNT_WIDTH-1:0] sts_drop_cnt
);

  localparam int unsigned HALF_W = AXIS_TDATA_WIDTH / 2;
  localparam int unsigned EXT_W  = HALF_W - ADC_DATA_WIDTH;
  localparam int unsigned CNT_W  = (2 ** DEC_LOG2_WIDTH) - 1;
  localparam int unsigned ACC_W  = ADC_DATA_WIDTH + CNT_W;

  logic [ADC_DATA_WIDTH-1:0]   dat_a_q, dat_b_q;
  logic                        s1_vld_q;
  logic [CNT_W-1:0]            cnt_q;
  logic [DEC_LOG2_WIDTH-1:0]   n_lat_q;
  logic signed [ACC_W-1:0]     acc_a_q, acc_b_q;
  logic [AXIS_TDATA_WIDTH-1:0] tdata_q;
  logic                        tvalid_q;
  logic                        ovf_q;
  logic [DROP_CNT_WIDTH-1:0]   drop_q;

  logic signed [ADC_DATA_WIDTH-1:0] conv_a, conv_b;
  logic signed [ACC_W-1:0]          base_a, base_b, sum_a, sum_b;
  logic signed [ADC_DATA_WIDTH-1:0] res_a, res_b;
  logic [DEC_LOG2_WIDTH-1:0]        n_eff;
  logic [CNT_W:0]                   last_idx;
  logic                             blk_start, blk_last, new_res;
  logic [AXIS_TDATA_WIDTH-1:0]      res_word;

  assign adc_csn = 1'b1;

  // Conversion, block accumulation and end-of-block result.
  always_comb begin
    conv_a    = {dat_a_q[ADC_DATA_WIDTH-1], ~dat_a_q[ADC_DATA_WIDTH-2:0]};
    conv_b    = {dat_b_q[ADC_DATA_WIDTH-1], ~dat_b_q[ADC_DATA_WIDTH-2:0]};
    blk_start = (cnt_q == '0);
    // The first sample of a block already uses the freshly sampled exponent.
    n_eff     = blk_start ? cfg_dec_log2 : n_lat_q;
    last_idx  = ((CNT_W+1)'(1) << n_eff) - (CNT_W+1)'(1);
    blk_last  = ({1'b0, cnt_q} == last_idx);
    new_res   = s1_vld_q && blk_last;
    base_a    = '0;
    base_b    = '0;
    if (!blk_start) begin
      base_a = acc_a_q;
      base_b = acc_b_q;
    end
    sum_a    = base_a + {{CNT_W{conv_a[ADC_DATA_WIDTH-1]}}, conv_a};
    sum_b    = base_b + {{CNT_W{conv_b[ADC_DATA_WIDTH-1]}}, conv_b};
    res_a    = ADC_DATA_WIDTH'(sum_a >>> n_eff);
    res_b    = ADC_DATA_WIDTH'(sum_b >>> n_eff);
    res_word = {{EXT_W{res_b[ADC_DATA_WIDTH-1]}}, res_b,
                {EXT_W{res_a[ADC_DATA_WIDTH-1]}}, res_a};
  end

  // Stage-1 capture, accumulator state and single-entry output register.
  always_ff @(posedge aclk) begin
    if (areset) begin
      dat_a_q  <= '0;
      dat_b_q  <= '0;
      s1_vld_q <= 1'b0;
      cnt_q    <= '0;
      n_lat_q  <= '0;
      acc_a_q  <= '0;
      acc_b_q  <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      dat_a_q  <= adc_dat_a;
      dat_b_q  <= adc_dat_b;
      // Stage 1 holds only the reset value on the first edge after reset.
      s1_vld_q <= 1'b1;
      if (s1_vld_q) begin
        if (blk_start) n_lat_q <= cfg_dec_log2;
        acc_a_q <= sum_a;
        acc_b_q <= sum_b;
        cnt_q   <= blk_last ? '0 : cnt_q + CNT_W'(1);
      end
      if (new_res) begin
        if (!tvalid_q || m_axis.tready) begin
          tdata_q  <= res_word;
          tvalid_q <= 1'b1;
        end else begin
          ovf_q <= 1'b1;
          if (drop_q != '1) drop_q <= drop_q + DROP_CNT_WIDTH'(1);
        end
      end else if (tvalid_q && m_axis.tready) begin
        tvalid_q <= 1'b0;
      end
    end
  end

  assign m_axis.tdata  = tdata_q;
  assign m_axis.tvalid = tvalid_q;
  assign sts_overflow  = ovf_q;
  assign sts_drop_cnt  = drop_q;

endmodule

// File: tb/tb_axis_red_pitaya_adc_capture.sv
module tb_axis_red_pitaya_adc_capture;

  logic        aclk;
  logic        areset;
  logic [13:0] adc_a, adc_b;
  logic [2:0]  cfg;
  logic        tready;
  logic        csn, csn4;
  logic        ovf, ovf4;
  logic [15:0] drop;
  logic [3:0]  drop4;

  axis_if #(.TDATA_WIDTH(32)) m_axis ();
  axis_if #(.TDATA_WIDTH(32)) m_axis4 ();
  assign m_axis.tready  = tready;
  assign m_axis4.tready = tready;

  axis_red_pitaya_adc_capture dut (
    .aclk(aclk), .areset(areset), .adc_dat_a(adc_a), .adc_dat_b(adc_b),
    .adc_csn(csn), .cfg_dec_log2(cfg), .m_axis(m_axis),
    .sts_overflow(ovf), .sts_drop_cnt(drop)
  );

  axis_red_pitaya_adc_capture #(.DROP_CNT_WIDTH(4)) dut4 (
    .aclk(aclk), .areset(areset), .adc_dat_a(adc_a), .adc_dat_b(adc_b),
    .adc_csn(csn4), .cfg_dec_log2(cfg), .m_axis(m_axis4),
    .sts_overflow(ovf4), .sts_drop_cnt(drop4)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Offset-binary code d maps to 8191 - d; averages floor toward minus infinity.
  function automatic int conv(input logic [13:0] d);
    return 8191 - int'(d);
  endfunction

  function automatic int floor_div(input int s, input int d);
    int q;
    q = s / d;
    if ((s % d != 0) && (s < 0)) q = q - 1;
    return q;
  endfunction

  bit          m_s1_ok;
  int          m_s1_a, m_s1_b;
  int          blk_a[$], blk_b[$];
  int          m_n;
  bit          exp_v;
  logic [31:0] exp_d;
  int          exp_drop;
  bit          exp_ovf;

  task automatic model_edge();
    int          sa, sb, ra, rb;
    bit          new_res;
    logic [31:0] res;
    new_res = 1'b0;
    res     = '0;
    if (areset) begin
      m_s1_ok  = 1'b0;
      blk_a.delete();
      blk_b.delete();
      exp_v    = 1'b0;
      exp_d    = '0;
      exp_drop = 0;
      exp_ovf  = 1'b0;
    end else begin
      if (m_s1_ok) begin
        if (blk_a.size() == 0) m_n = int'(cfg);
        blk_a.push_back(m_s1_a);
        blk_b.push_back(m_s1_b);
        if (blk_a.size() == (1 << m_n)) begin
          sa = 0;
          sb = 0;
          foreach (blk_a[i]) sa += blk_a[i];
          foreach (blk_b[i]) sb += blk_b[i];
          ra = floor_div(sa, 1 << m_n);
          rb = floor_div(sb, 1 << m_n);
          res = {16'(rb), 16'(ra)};
          new_res = 1'b1;
          blk_a.delete();
          blk_b.delete();
        end
      end
      if (new_res) begin
        if (!exp_v || tready) begin
          exp_d = res;
          exp_v = 1'b1;
        end else begin
          exp_ovf = 1'b1;
          exp_drop++;
        end
      end else if (exp_v && tready) begin
        exp_v = 1'b0;
      end
      m_s1_a  = conv(adc_a);
      m_s1_b  = conv(adc_b);
      m_s1_ok = 1'b1;
    end
  endtask

  task automatic check_model();
    check("tvalid", 32'(m_axis.tvalid), 32'(exp_v));
    check("tdata", m_axis.tdata, exp_d);
    check("overflow", 32'(ovf), 32'(exp_ovf));
    check("drop_cnt", 32'(drop), (exp_drop > 65535) ? 32'd65535 : 32'(exp_drop));
    check("tvalid_w4", 32'(m_axis4.tvalid), 32'(exp_v));
    check("tdata_w4", m_axis4.tdata, exp_d);
    check("overflow_w4", 32'(ovf4), 32'(exp_ovf));
    check("drop_cnt_w4", 32'(drop4), (exp_drop > 15) ? 32'd15 : 32'(exp_drop));
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic tick();
    @(posedge aclk);
    model_edge();
    @(negedge aclk);
    check_model();
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [13:0] a;
    logic [13:0] b;
    bit          chk;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[6];
  int   beats, last_beat, sum_a, sum_b;
  logic [13:0] sa_q[8], sb_q[8];

  initial begin
    tbl[0] = '{14'h0000, 14'h2000, 1'b0, 32'h0000_0000};
    tbl[1] = '{14'h1FFF, 14'h0000, 1'b1, 32'hFFFF_1FFF};
    tbl[2] = '{14'h2000, 14'h1FFF, 1'b1, 32'h1FFF_0000};
    tbl[3] = '{14'h3FFF, 14'h2000, 1'b1, 32'h0000_FFFF};
    tbl[4] = '{14'h1FFF, 14'h3FFF, 1'b1, 32'hFFFF_E000};
    tbl[5] = '{14'h1FFF, 14'h1FFF, 1'b1, 32'hE000_0000};

    areset = 1'b1;
    adc_a  = '0;
    adc_b  = '0;
    cfg    = 3'd0;
    tready = 1'b1;
    m_n    = 0;
    tick();
    tick();
    check("rst_tvalid", 32'(m_axis.tvalid), 32'd0);
    check("rst_tdata", m_axis.tdata, 32'd0);
    check("rst_drop", 32'(drop), 32'd0);
    check("adc_csn", 32'(csn), 32'd1);
    areset = 1'b0;

    // Conversion, N=0, channel B lags channel A by one cycle.
    for (int i = 0; i < 6; i++) begin
      adc_a = tbl[i].a;
      adc_b = tbl[i].b;
      tick();
      if (tbl[i].chk) begin
        check("conv_tdata", m_axis.tdata, tbl[i].exp);
        check("conv_tvalid", 32'(m_axis.tvalid), 32'd1);
      end
    end

    // Averaging floor, N=2: any 4-window of {-1,-1,-1,0} averages to -1.
    cfg = 3'd2;
    beats = 0;
    last_beat = 0;
    for (int i = 0; i < 20; i++) begin
      adc_a = (i % 4 == 3) ? 14'h1FFF : 14'h2000;
      adc_b = 14'($urandom);
      tick();
      if (m_axis.tvalid) begin
        check("avg2_tdata_a", 32'(m_axis.tdata[15:0]), 32'h0000_FFFF);
        if (beats > 0) check("avg2_period", 32'(i - last_beat), 32'd4);
        beats++;
        last_beat = i;
      end
    end
    check("avg2_beats", 32'(beats), 32'd5);

    // Constant +100 / -100 over N=3 (flush one N=2 block first).
    adc_a = 14'h1F9B;
    adc_b = 14'h2063;
    for (int i = 0; i < 4; i++) tick();
    cfg = 3'd3;
    beats = 0;
    last_beat = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (m_axis.tvalid) begin
        check("avg3_tdata", m_axis.tdata, 32'hFF9C_0064);
        if (beats > 0) check("avg3_period", 32'(i - last_beat), 32'd8);
        beats++;
        last_beat = i;
      end
    end
    check("avg3_beats", 32'(beats), 32'd3);

    // Backpressure, N=0.
    areset = 1'b1;
    cfg = 3'd0;
    tick();
    areset = 1'b0;
    tready = 1'b1;
    adc_a = 14'h0100;
    adc_b = 14'h3000;
    for (int i = 0; i < 3; i++) tick();
    check("bp_r0", m_axis.tdata, 32'hEFFF_1EFF);
    adc_a = 14'h2345;
    adc_b = 14'h0ABC;
    tready = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("bp_hold", m_axis.tdata, 32'hEFFF_1EFF);
    check("bp_drop", 32'(drop), 32'd5);
    check("bp_ovf", 32'(ovf), 32'd1);
    tready = 1'b1;
    tick();
    check("bp_newest", m_axis.tdata, 32'h1543_FCBA);
    check("bp_newest_v", 32'(m_axis.tvalid), 32'd1);
    tick();
    check("bp_nogap_v", 32'(m_axis.tvalid), 32'd1);

    // Drop counter saturation.
    tready = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("sat_drop4", 32'(drop4), 32'hF);
    check("sat_drop16", 32'(drop), 32'd25);
    tready = 1'b1;

    // Reset mid-block, N=3.
    cfg = 3'd3;
    areset = 1'b1;
    tick();
    areset = 1'b0;
    adc_a = 14'h3FFF;
    adc_b = 14'h0000;
    for (int i = 0; i < 5; i++) tick();
    areset = 1'b1;
    tick();
    check("midrst_tvalid", 32'(m_axis.tvalid), 32'd0);
    check("midrst_ovf", 32'(ovf), 32'd0);
    check("midrst_drop", 32'(drop), 32'd0);
    areset = 1'b0;
    sum_a = 0;
    sum_b = 0;
    for (int i = 0; i < 8; i++) begin
      sa_q[i] = 14'($urandom);
      sb_q[i] = 14'($urandom);
      sum_a += conv(sa_q[i]);
      sum_b += conv(sb_q[i]);
      adc_a = sa_q[i];
      adc_b = sb_q[i];
      tick();
      check("midrst_quiet", 32'(m_axis.tvalid), 32'd0);
    end
    adc_a = 14'h0000;
    adc_b = 14'h0000;
    tick();
    check("midrst_first_v", 32'(m_axis.tvalid), 32'd1);
    check("midrst_first_d", m_axis.tdata,
          {16'(floor_div(sum_b, 8)), 16'(floor_div(sum_a, 8))});

    // Config change mid-block: N=2 -> N=0 after the 2nd sample.
    cfg = 3'd2;
    areset = 1'b1;
    tick();
    areset = 1'b0;
    sum_a = 0;
    sum_b = 0;
    for (int i = 0; i < 7; i++) begin
      sa_q[i] = 14'($urandom);
      sb_q[i] = 14'($urandom);
    end
    for (int i = 0; i < 4; i++) begin
      if (i == 2) cfg = 3'd0;
      sum_a += conv(sa_q[i]);
      sum_b += conv(sb_q[i]);
      adc_a = sa_q[i];
      adc_b = sb_q[i];
      tick();
      check("cfgchg_quiet", 32'(m_axis.tvalid), 32'd0);
    end
    adc_a = sa_q[4];
    adc_b = sb_q[4];
    tick();
    check("cfgchg_blk_v", 32'(m_axis.tvalid), 32'd1);
    check("cfgchg_blk_d", m_axis.tdata,
          {16'(floor_div(sum_b, 4)), 16'(floor_div(sum_a, 4))});
    for (int i = 5; i < 7; i++) begin
      adc_a = sa_q[i];
      adc_b = sb_q[i];
      tick();
      check("cfgchg_each_v", 32'(m_axis.tvalid), 32'd1);
      check("cfgchg_each_d", m_axis.tdata,
            {16'(conv(sb_q[i-1])), 16'(conv(sa_q[i-1]))});
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 9))
        0:       adc_a = 14'h0000;
        1:       adc_a = 14'h3FFF;
        default: adc_a = 14'($urandom);
      endcase
      adc_b  = 14'($urandom);
      tready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) cfg = 3'($urandom_range(0, 7));
      areset = ($urandom_range(0, 499) == 0);
      tick();
    end
    areset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axis_red_pitaya_adc_capture.md
Name: axis_red_pitaya_adc_capture

Overview:
- Receive side of the Red Pitaya analog front end: captures dual-channel ADC samples and converts them from offset-binary to two's complement.
- Optionally box-car averages each channel over 2^N samples, set at runtime.
- Presents the result as an AXI4-Stream master.
- Sits between the ADC pins and the downstream DSP/DMA chain, mirroring the DAC output path.

Parameters:
- ADC_DATA_WIDTH, 14, ADC sample width per channel.
- AXIS_TDATA_WIDTH, 32, stream width; each channel occupies one half (AXIS_TDATA_WIDTH/2 bits).
- DEC_LOG2_WIDTH, 3, width of the decimation-exponent input; max exponent 2^DEC_LOG2_WIDTH-1.
- DROP_CNT_WIDTH, 16, width of the dropped-result counter.

Ports:
- aclk  in  1  ADC sample clock; the only clock.
- areset  in  1  synchronous, active-high reset.
- adc_dat_a  in  ADC_DATA_WIDTH  channel A raw offset-binary sample.
- adc_dat_b  in  ADC_DATA_WIDTH  channel B raw offset-binary sample.
- adc_csn  out  1  ADC chip select, constant 1.
- cfg_dec_log2  in  DEC_LOG2_WIDTH  averaging exponent N; block length is 2^N.
- m_axis_tdata  out  AXIS_TDATA_WIDTH  [15:0] channel A, [31:16] channel B (for the default 32-bit width).
- m_axis_tvalid  out  1  result valid.
- m_axis_tready  in  1  downstream ready.
- sts_overflow  out  1  sticky: at least one result dropped.
- sts_drop_cnt  out  DROP_CNT_WIDTH  number of dropped results, saturating.

Behaviour:
- Synchronous active-high reset on every edge where areset=1. Reset values:
  - m_axis_tvalid=0, m_axis_tdata=0, sts_overflow=0, sts_drop_cnt=0.
  - Sample counter=0, both accumulators=0, stage-1 registers=0, latched N=0.
  - A partial block is discarded.
- Stage 1: adc_dat_a and adc_dat_b are registered on every aclk edge, with no enable.
- Conversion: conv = {d[MSB], ~d[MSB-1:0]}, interpreted as signed. Examples: 14'h0000 -> +8191; 14'h3FFF -> -8192.
- Accumulation:
  - Per-channel signed accumulator, width ADC_DATA_WIDTH+2^DEC_LOG2_WIDTH-1.
  - The counter runs 0..2^N-1.
  - At count 0, the accumulator loads conv and N is latched from cfg_dec_log2.
  - Otherwise the accumulator adds conv.
  - A cfg_dec_log2 change mid-block takes effect at the next block start.
- Result:
  - When the counter reaches 2^N-1, result = (acc + conv) >>> N_latched. The shift is arithmetic, i.e. floor toward minus infinity.
  - The result is truncated to ADC_DATA_WIDTH, then sign-extended to AXIS_TDATA_WIDTH/2.
  - The counter then wraps to 0.
- Latency:
  - Sample on pins before edge k is in stage 1 after edge k.
  - For N=0, it is on m_axis_tdata with tvalid=1 after edge k+1.
  - For N>0, the result of a block appears one edge after stage 1 holds its last sample.
- Output register (single entry). At each edge with a new result:
  - tvalid=0, or tvalid=1 and tready=1: load result, tvalid=1.
  - tvalid=1 and tready=0: keep tdata unchanged, drop the new result, set sts_overflow, increment sts_drop_cnt.
  - Without a new result: tvalid=1 and tready=1 clears tvalid.
  - A transfer and a new result on the same edge is a load, never a drop.
- sts_drop_cnt saturates at all-ones. sts_overflow and sts_drop_cnt clear only on reset.
- tdata is stable while tvalid=1 and tready=0 (AXIS rule).
- The accumulation path never stalls: sampling is continuous regardless of tready.

Test Plan:
- Conversion, N=0, tready=1: adc_dat_a=14'h0000, 14'h1FFF, 14'h2000, 14'h3FFF on consecutive cycles -> tdata[15:0]=0x1FFF, 0x0000, 0xFFFF, 0xE000, one cycle after stage 1. Channel B is driven with the same pattern, delayed one cycle -> matching values in [31:16].
- Averaging floor, N=2: channel A raw samples give conv -1,-1,-1,0 -> one beat per 4 cycles with tdata[15:0]=0xFFFF. Constant conv +100 over N=3 -> a beat every 8 cycles with value 0x0064.
- Backpressure, N=0:
  - First result R0 valid, then tready=0 for 5 edges -> tdata holds R0, sts_drop_cnt=5, sts_overflow=1.
  - tready=1 -> R0 accepted; the next beat is the newest sample with no gap.
- Drop counter saturation: DROP_CNT_WIDTH=4, tready=0 for 20 result edges -> sts_drop_cnt stays at 0xF.
- Reset mid-block, N=3: assert areset after the 5th sample for one cycle.
  - During and after reset: tvalid=0, counters 0.
  - The first result appears exactly 8 samples after reset deasserts, and the averaged value excludes pre-reset samples.
- Config change mid-block: N=2, change to N=0 after the 2nd sample of a block -> that block still completes over 4 samples, then beats arrive every cycle.
